// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core.
// It decodes the opcode and sequences the ALU, the register file, the PC/IR registers and the memory
// port, one instruction at a time. A watchdog traps a memory handshake that stalls.
module multicycle_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TIMEOUT_W   = 8
) (
   input  logic       MCC_CLOCK_50,
   input  logic       MCC_RESET_InLow,
   input  logic [6:0] MCC_Opcode_InBUS,
   input  logic       MCC_MemAck_In,
   output logic       MCC_MemReq_Out,
   output logic       MCC_MemWrite_Out,
   output logic       MCC_IorD_Out,
   output logic       MCC_IrWrite_Out,
   output logic       MCC_PcWrite_Out,
   output logic       MCC_PcWriteCond_Out,
   output logic       MCC_PcSrc_Out,
   output logic       MCC_OldPcWrite_Out,
   output logic [1:0] MCC_AluOP_OutBUS,
   output logic [1:0] MCC_AluSrcA_OutBUS,
   output logic [1:0] MCC_AluSrcB_OutBUS,
   output logic       MCC_RegWrite_Out,
   output logic [1:0] MCC_ResultSrc_OutBUS,
   output logic       MCC_InstRetired_Out,
   output logic       MCC_Trap_Out,
   output logic       MCC_TrapCause_Out,
   output logic [3:0] MCC_State_OutBUS
);

   typedef enum logic [3:0] {
      S_BOOT     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_LUI      = 4'd5,
      S_JALR     = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_MEM_WB   = 4'd10,
      S_ALU_WB   = 4'd11,
      S_JUMP_WB  = 4'd12,
      S_BRANCH   = 4'd13,
      S_TRAP     = 4'd15
   } state_e;

   // Watchdog value seen on the last permitted wait cycle: another miss means MEM_TIMEOUT cycles elapsed.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

   state_e               state_q;
   logic [TIMEOUT_W-1:0] wd_q;
   logic                 trap_q;
   logic                 cause_q;
   logic                 wd_expired;

   assign wd_expired = (wd_q == WD_LAST);

   // State, watchdog and sticky trap. The watchdog is cleared on every cycle except a stalled wait,
   // so entering a memory state or receiving an ack always restarts it.
   always_ff @(posedge MCC_CLOCK_50) begin
      if (!MCC_RESET_InLow) begin
         state_q <= S_BOOT;
         wd_q    <= '0;
         trap_q  <= 1'b0;
         cause_q <= 1'b0;
      end else begin
         wd_q <= '0;
         case (state_q)
            S_BOOT:     state_q <= S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
               if (MCC_MemAck_In) begin
                  // An ack on the timeout cycle still completes the transaction.
                  case (state_q)
                     S_FETCH:  state_q <= S_DECODE;
                     S_MEM_RD: state_q <= S_MEM_WB;
                     default:  state_q <= S_FETCH;
                  endcase
               end else if (wd_expired) begin
                  state_q <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            S_DECODE: begin
               case (MCC_Opcode_InBUS)
                  7'b0110011:             state_q <= S_EXEC_R;
                  7'b0010011:             state_q <= S_EXEC_I;
                  7'b0000011, 7'b0100011: state_q <= S_MEM_ADDR;
                  7'b0110111:             state_q <= S_LUI;
                  7'b0010111:             state_q <= S_ALU_WB;
                  7'b1101111:             state_q <= S_JUMP_WB;
                  7'b1100111:             state_q <= S_JALR;
                  7'b1100011:             state_q <= S_BRANCH;
                  default: begin
                     state_q <= S_TRAP;
                     trap_q  <= 1'b1;
                     cause_q <= 1'b0;
                  end
               endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI: state_q <= S_ALU_WB;
            S_JALR:     state_q <= S_JUMP_WB;
            S_MEM_ADDR: state_q <= MCC_Opcode_InBUS[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_WB, S_ALU_WB, S_JUMP_WB, S_BRANCH: state_q <= S_FETCH;
            S_TRAP:     state_q <= S_TRAP;
            default: begin
               state_q <= S_TRAP;
               trap_q  <= 1'b1;
               cause_q <= 1'b0;
            end
         endcase
      end
   end

   // Moore decode of the control word. The fetch writes and the store retire are qualified by the ack.
   always_comb begin
      MCC_MemReq_Out       = 1'b0;
      MCC_MemWrite_Out     = 1'b0;
      MCC_IorD_Out         = 1'b0;
      MCC_IrWrite_Out      = 1'b0;
      MCC_PcWrite_Out      = 1'b0;
      MCC_PcWriteCond_Out  = 1'b0;
      MCC_PcSrc_Out        = 1'b0;
      MCC_OldPcWrite_Out   = 1'b0;
      MCC_AluOP_OutBUS     = 2'b00;
      MCC_AluSrcA_OutBUS   = 2'b00;
      MCC_AluSrcB_OutBUS   = 2'b00;
      MCC_RegWrite_Out     = 1'b0;
      MCC_ResultSrc_OutBUS = 2'b00;
      MCC_InstRetired_Out  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MCC_MemReq_Out     = 1'b1;
            MCC_AluSrcB_OutBUS = 2'b10;
            MCC_AluOP_OutBUS   = 2'b01;
            MCC_IrWrite_Out    = MCC_MemAck_In;
            MCC_PcWrite_Out    = MCC_MemAck_In;
            MCC_OldPcWrite_Out = MCC_MemAck_In;
         end
         S_DECODE: begin
            MCC_AluSrcA_OutBUS = 2'b01;
            MCC_AluSrcB_OutBUS = 2'b01;
            MCC_AluOP_OutBUS   = 2'b01;
         end
         S_EXEC_R: MCC_AluSrcA_OutBUS = 2'b10;
         S_EXEC_I: begin
            MCC_AluSrcA_OutBUS = 2'b10;
            MCC_AluSrcB_OutBUS = 2'b01;
         end
         S_LUI: begin
            MCC_AluSrcA_OutBUS = 2'b11;
            MCC_AluOP_OutBUS   = 2'b10;
         end
         S_JALR, S_MEM_ADDR: begin
            MCC_AluSrcA_OutBUS = 2'b10;
            MCC_AluSrcB_OutBUS = 2'b01;
            MCC_AluOP_OutBUS   = 2'b01;
         end
         S_MEM_RD: begin
            MCC_MemReq_Out = 1'b1;
            MCC_IorD_Out   = 1'b1;
         end
         S_MEM_WR: begin
            MCC_MemReq_Out      = 1'b1;
            MCC_MemWrite_Out    = 1'b1;
            MCC_IorD_Out        = 1'b1;
            MCC_InstRetired_Out = MCC_MemAck_In;
         end
         S_MEM_WB: begin
            MCC_RegWrite_Out     = 1'b1;
            MCC_ResultSrc_OutBUS = 2'b01;
            MCC_InstRetired_Out  = 1'b1;
         end
         S_ALU_WB: begin
            MCC_RegWrite_Out    = 1'b1;
            MCC_InstRetired_Out = 1'b1;
         end
         S_JUMP_WB: begin
            MCC_RegWrite_Out     = 1'b1;
            MCC_ResultSrc_OutBUS = 2'b10;
            MCC_PcWrite_Out      = 1'b1;
            MCC_PcSrc_Out        = 1'b1;
            MCC_InstRetired_Out  = 1'b1;
         end
         S_BRANCH: begin
            MCC_AluSrcA_OutBUS  = 2'b10;
            MCC_PcWriteCond_Out = 1'b1;
            MCC_PcSrc_Out       = 1'b1;
            MCC_InstRetired_Out = 1'b1;
         end
         default: ;
      endcase
   end

   assign MCC_Trap_Out      = trap_q;
   assign MCC_TrapCause_Out = cause_q;
   assign MCC_State_OutBUS  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: instance a uses the default watchdog, and instance b uses a
// 4-cycle watchdog. Both instances share all inputs.
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opc = 7'd0;
   logic       ack = 1'b0;

   logic mreq_a, mwr_a, iord_a, irw_a, pcw_a, pcwc_a, pcsrc_a, opcw_a, regw_a, ret_a, trap_a, cause_a;
   logic [1:0] aluop_a, srca_a, srcb_a, res_a;
   logic [3:0] st_a;
   logic mreq_b, mwr_b, iord_b, irw_b, pcw_b, pcwc_b, pcsrc_b, opcw_b, regw_b, ret_b, trap_b, cause_b;
   logic [1:0] aluop_b, srca_b, srcb_b, res_b;
   logic [3:0] st_b;

   int n = 0;
   int e = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm dut_a (
      .MCC_CLOCK_50(clk), .MCC_RESET_InLow(rst_n), .MCC_Opcode_InBUS(opc), .MCC_MemAck_In(ack),
      .MCC_MemReq_Out(mreq_a), .MCC_MemWrite_Out(mwr_a), .MCC_IorD_Out(iord_a),
      .MCC_IrWrite_Out(irw_a), .MCC_PcWrite_Out(pcw_a), .MCC_PcWriteCond_Out(pcwc_a),
      .MCC_PcSrc_Out(pcsrc_a), .MCC_OldPcWrite_Out(opcw_a), .MCC_AluOP_OutBUS(aluop_a),
      .MCC_AluSrcA_OutBUS(srca_a), .MCC_AluSrcB_OutBUS(srcb_a), .MCC_RegWrite_Out(regw_a),
      .MCC_ResultSrc_OutBUS(res_a), .MCC_InstRetired_Out(ret_a), .MCC_Trap_Out(trap_a),
      .MCC_TrapCause_Out(cause_a), .MCC_State_OutBUS(st_a)
   );

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut_b (
      .MCC_CLOCK_50(clk), .MCC_RESET_InLow(rst_n), .MCC_Opcode_InBUS(opc), .MCC_MemAck_In(ack),
      .MCC_MemReq_Out(mreq_b), .MCC_MemWrite_Out(mwr_b), .MCC_IorD_Out(iord_b),
      .MCC_IrWrite_Out(irw_b), .MCC_PcWrite_Out(pcw_b), .MCC_PcWriteCond_Out(pcwc_b),
      .MCC_PcSrc_Out(pcsrc_b), .MCC_OldPcWrite_Out(opcw_b), .MCC_AluOP_OutBUS(aluop_b),
      .MCC_AluSrcA_OutBUS(srca_b), .MCC_AluSrcB_OutBUS(srcb_b), .MCC_RegWrite_Out(regw_b),
      .MCC_ResultSrc_OutBUS(res_b), .MCC_InstRetired_Out(ret_b), .MCC_Trap_Out(trap_b),
      .MCC_TrapCause_Out(cause_b), .MCC_State_OutBUS(st_b)
   );

   // advance one cycle; sample 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reset for two cycles and release; the FSM is left in BOOT
   task automatic restart();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ack = 1'b1; opc = 7'b0110011;
      tick(); tick(); tick();
      n++; if (st_a !== 4'd0) begin e++; $display("FAIL reset_state got=%0d exp=0", st_a); end
      n++; if (mreq_a !== 1'b0 || trap_a !== 1'b0 || cause_a !== 1'b0 || irw_a !== 1'b0)
         begin e++; $display("FAIL reset_outputs req=%b trap=%b cause=%b irw=%b exp=0", mreq_a, trap_a, cause_a, irw_a); end
      rst_n = 1'b1;
      tick();
      n++; if (st_a !== 4'd1 || mreq_a !== 1'b1) begin e++; $display("FAIL boot_to_fetch st=%0d req=%b exp=1/1", st_a, mreq_a); end
      n++; if ({irw_a, pcw_a, opcw_a, pcsrc_a, iord_a, srca_a, srcb_a, aluop_a} !== 11'b111_0_0_00_10_01)
         begin e++; $display("FAIL fetch_ack_ctl got=%b exp=11100001001", {irw_a, pcw_a, opcw_a, pcsrc_a, iord_a, srca_a, srcb_a, aluop_a}); end
      tick();
      n++; if (st_a !== 4'd2 || mreq_a !== 1'b0) begin e++; $display("FAIL fetch_to_decode st=%0d req=%b exp=2/0", st_a, mreq_a); end
   endtask

   task automatic test_add();
      restart();
      opc = 7'b0110011; ack = 1'b1;
      tick();
      n++; if (st_a !== 4'd1 || ret_a !== 1'b0) begin e++; $display("FAIL add_fetch st=%0d ret=%b exp=1/0", st_a, ret_a); end
      tick();
      n++; if ({srca_a, srcb_a, aluop_a, regw_a, ret_a} !== 8'b01_01_01_0_0)
         begin e++; $display("FAIL add_decode got=%b exp=01010100", {srca_a, srcb_a, aluop_a, regw_a, ret_a}); end
      tick();
      n++; if (st_a !== 4'd3 || {srca_a, srcb_a, aluop_a, regw_a, ret_a} !== 8'b10_00_00_0_0)
         begin e++; $display("FAIL add_exec st=%0d ctl=%b exp=3/10000000", st_a, {srca_a, srcb_a, aluop_a, regw_a, ret_a}); end
      tick();
      n++; if (st_a !== 4'd11 || regw_a !== 1'b1 || ret_a !== 1'b1 || res_a !== 2'b00)
         begin e++; $display("FAIL add_wb st=%0d regw=%b ret=%b res=%b exp=11/1/1/00", st_a, regw_a, ret_a, res_a); end
      tick();
      n++; if (st_a !== 4'd1 || regw_a !== 1'b0 || ret_a !== 1'b0)
         begin e++; $display("FAIL add_next_fetch st=%0d regw=%b ret=%b exp=1/0/0", st_a, regw_a, ret_a); end
   endtask

   task automatic test_load_wait();
      int reqs;
      restart();
      opc = 7'b0000011; ack = 1'b1;
      tick(); tick(); tick();
      n++; if (st_a !== 4'd7 || srca_a !== 2'b10 || srcb_a !== 2'b01 || aluop_a !== 2'b01)
         begin e++; $display("FAIL load_addr st=%0d a=%b b=%b op=%b exp=7/10/01/01", st_a, srca_a, srcb_a, aluop_a); end
      ack = 1'b0;
      reqs = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         if (st_a === 4'd8 && mreq_a === 1'b1 && iord_a === 1'b1 && mwr_a === 1'b0) reqs++;
         tick();
      end
      ack = 1'b1;
      #1;
      if (st_a === 4'd8 && mreq_a === 1'b1 && iord_a === 1'b1) reqs++;
      n++; if (reqs !== 6) begin e++; $display("FAIL load_req_cycles got=%0d exp=6", reqs); end
      tick();
      n++; if (st_a !== 4'd10 || res_a !== 2'b01 || regw_a !== 1'b1 || ret_a !== 1'b1)
         begin e++; $display("FAIL load_wb st=%0d res=%b regw=%b ret=%b exp=10/01/1/1", st_a, res_a, regw_a, ret_a); end
   endtask

   task automatic test_timeout();
      int waits;
      restart();
      ack = 1'b0; opc = 7'b0110011;
      tick();
      waits = 0;
      for (int i = 0; i < 10 && st_b === 4'd1; i++) begin
         waits++;
         tick();
      end
      n++; if (waits !== 4) begin e++; $display("FAIL timeout_wait_cycles got=%0d exp=4", waits); end
      n++; if (st_b !== 4'd15 || trap_b !== 1'b1 || cause_b !== 1'b1 || mreq_b !== 1'b0)
         begin e++; $display("FAIL timeout_trap st=%0d trap=%b cause=%b req=%b exp=15/1/1/0", st_b, trap_b, cause_b, mreq_b); end
      n++; if (st_a !== 4'd1 || trap_a !== 1'b0) begin e++; $display("FAIL default_wd_no_trap st=%0d trap=%b exp=1/0", st_a, trap_a); end
      ack = 1'b1;
      tick(); tick();
      ack = 1'b0;
      tick();
      n++; if (st_b !== 4'd15 || trap_b !== 1'b1 || cause_b !== 1'b1)
         begin e++; $display("FAIL timeout_sticky st=%0d trap=%b cause=%b exp=15/1/1", st_b, trap_b, cause_b); end
   endtask

   task automatic test_ack_at_timeout();
      restart();
      ack = 1'b0; opc = 7'b0110011;
      tick(); tick(); tick(); tick();
      ack = 1'b1;
      tick();
      n++; if (st_b !== 4'd2 || trap_b !== 1'b0) begin e++; $display("FAIL ack_wins_timeout st=%0d trap=%b exp=2/0", st_b, trap_b); end
   endtask

   task automatic test_illegal();
      restart();
      opc = 7'b0000000; ack = 1'b1;
      tick(); tick();
      n++; if (st_a !== 4'd2) begin e++; $display("FAIL illegal_decode st=%0d exp=2", st_a); end
      tick();
      n++; if (st_a !== 4'd15 || trap_a !== 1'b1 || cause_a !== 1'b0 || mreq_a !== 1'b0 || regw_a !== 1'b0)
         begin e++; $display("FAIL illegal_trap st=%0d trap=%b cause=%b req=%b regw=%b exp=15/1/0/0/0", st_a, trap_a, cause_a, mreq_a, regw_a); end
      ack = 1'b0; tick();
      ack = 1'b1; tick();
      ack = 1'b0; tick();
      n++; if (st_a !== 4'd15 || trap_a !== 1'b1 || cause_a !== 1'b0)
         begin e++; $display("FAIL illegal_sticky st=%0d trap=%b cause=%b exp=15/1/0", st_a, trap_a, cause_a); end
   endtask

   task automatic test_reset_in_store();
      restart();
      opc = 7'b0100011; ack = 1'b1;
      tick(); tick(); tick();
      ack = 1'b0;
      tick();
      n++; if (st_a !== 4'd9 || mreq_a !== 1'b1 || mwr_a !== 1'b1 || iord_a !== 1'b1 || ret_a !== 1'b0)
         begin e++; $display("FAIL store_wait st=%0d req=%b wr=%b iord=%b ret=%b exp=9/1/1/1/0", st_a, mreq_a, mwr_a, iord_a, ret_a); end
      ack = 1'b1; rst_n = 1'b0;
      tick();
      n++; if (st_a !== 4'd0 || regw_a !== 1'b0 || pcw_a !== 1'b0 || trap_a !== 1'b0 || mreq_a !== 1'b0)
         begin e++; $display("FAIL reset_mid_store st=%0d regw=%b pcw=%b trap=%b req=%b exp=0/0/0/0/0", st_a, regw_a, pcw_a, trap_a, mreq_a); end
      rst_n = 1'b1;
   endtask

   task automatic test_jal_latency();
      int cyc;
      restart();
      opc = 7'b1101111; ack = 1'b1;
      tick();
      cyc = 1;
      while (ret_a !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      n++; if (cyc !== 3) begin e++; $display("FAIL jal_latency got=%0d exp=3", cyc); end
      n++; if (st_a !== 4'd12 || {regw_a, res_a, pcw_a, pcsrc_a} !== 5'b1_10_1_1)
         begin e++; $display("FAIL jal_wb st=%0d ctl=%b exp=12/11011", st_a, {regw_a, res_a, pcw_a, pcsrc_a}); end
   endtask

   task automatic test_decode_table();
      logic [6:0] opcs [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1111111};
      logic [3:0] exps [10] = '{4'd3, 4'd4, 4'd7, 4'd7, 4'd5, 4'd11, 4'd12, 4'd6, 4'd13, 4'd15};
      for (int i = 0; i < 10; i++) begin
         restart();
         opc = opcs[i]; ack = 1'b1;
         tick(); tick(); tick();
         n++; if (st_a !== exps[i]) begin e++; $display("FAIL decode_%b got=%0d exp=%0d", opcs[i], st_a, exps[i]); end
      end
      // branch control word, checked while in BRANCH
      n++; if (pcwc_a !== 1'b0) begin e++; $display("FAIL pcwc_outside_branch got=%b exp=0", pcwc_a); end
      restart();
      opc = 7'b1100011;
      tick(); tick(); tick();
      n++; if ({pcwc_a, pcsrc_a, srca_a, srcb_a, ret_a, pcw_a} !== 8'b1_1_10_00_1_0)
         begin e++; $display("FAIL branch_ctl got=%b exp=11100010", {pcwc_a, pcsrc_a, srca_a, srcb_a, ret_a, pcw_a}); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_timeout();
      test_ack_at_timeout();
      test_illegal();
      test_reset_in_store();
      test_jal_latency();
      test_decode_table();
      $display("Result: errors=%0d of %0d checks", e, n);
      $finish;
   end

endmodule
